// File: rtl/uart_word_loader.sv
// Receive end of the UART word dump: packs 4 bytes (LSB first) into 32-bit BRAM words, y fastest, then x, then idx.
// Optional inter-byte gap timeout is enabled with `define UART_LOADER_TIMEOUT_EN.
module uart_word_loader #(
    parameter int Y_LAST         = 11,
    parameter int X_LAST         = 11,
    parameter int IDX_LAST       = 7,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_irdy,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [3:0] Y_L   = Y_LAST[3:0];
    localparam logic [3:0] X_L   = X_LAST[3:0];
    localparam logic [2:0] IDX_L = IDX_LAST[2:0];

    state_t      state, state_nxt;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;
    logic [3:0]  y, x;
    logic [2:0]  idx;
    logic        accept, at_end, word_last, timeout;

    // Bytes are only taken while loading; a strobe in IDLE/DONE is dropped.
    assign accept    = (state == RECV) && rx_irdy;
    assign at_end    = (y == Y_L) && (x == X_L) && (idx == IDX_L);
    assign word_last = accept && (byte_idx == 2'd3);
    assign busy      = (state == RECV);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV:    if (word_last && at_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= 2'd0;
            word_lo  <= 24'd0;
            y        <= 4'd0;
            x        <= 4'd0;
            idx      <= 3'd0;
            mem_we   <= 1'b0;
            mem_addr <= 11'd0;
            mem_data <= 32'd0;
            done     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= (state == DONE);
            if (state == IDLE && start) begin
                byte_idx <= 2'd0;
                y        <= 4'd0;
                x        <= 4'd0;
                idx      <= 3'd0;
            end
            if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_lo[7:0]   <= rx_data;
                    2'd1: word_lo[15:8]  <= rx_data;
                    2'd2: word_lo[23:16] <= rx_data;
                    default: begin
                        // Fourth byte goes straight to the write port, so a byte in the
                        // mem_we cycle already lands as byte 0 of the next word.
                        mem_we   <= 1'b1;
                        mem_data <= {rx_data, word_lo};
                        mem_addr <= {idx, x, y};
                        if (y == Y_L) begin
                            y <= 4'd0;
                            if (x == X_L) begin
                                x   <= 4'd0;
                                idx <= idx + 3'd1;
                            end else begin
                                x <= x + 4'd1;
                            end
                        end else begin
                            y <= y + 4'd1;
                        end
                    end
                endcase
            end else if (timeout) begin
                byte_idx <= 2'd0;
            end
        end
    end

`ifdef UART_LOADER_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] gap_cnt;
    logic        err_r;

    assign timeout = (state == RECV) && !rx_irdy && (byte_idx != 2'd0) && (gap_cnt == TO_LAST);
    assign err     = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            err_r <= timeout;
            if (accept || timeout || state != RECV) gap_cnt <= 32'd0;
            else if (byte_idx != 2'd0)              gap_cnt <= gap_cnt + 32'd1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: expected {addr,data} writes are queued as bytes are sent
// and checked when mem_we fires. Define UART_LOADER_TIMEOUT_EN to exercise the gap timeout.
module tb_uart_word_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_irdy;
    logic [7:0]  rx_data;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int done_cnt = 0;
    int wc       = 0;
    logic [42:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef UART_LOADER_TIMEOUT_EN
    uart_word_loader #(.TIMEOUT_CYCLES(50)) dut (
`else
    uart_word_loader dut (
`endif
        .clk(clk), .rst(rst), .start(start), .rx_irdy(rx_irdy), .rx_data(rx_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Address of the n-th word with default geometry: 12 y, 12 x per idx.
    function automatic logic [10:0] model_addr(input int n);
        int yy, xx, ii;
        yy = n % 12;
        xx = (n / 12) % 12;
        ii = n / 144;
        return {ii[2:0], xx[3:0], yy[3:0]};
    endfunction

    // Driver tasks: entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        rx_irdy = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_irdy = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int max_gap);
        exp_q.push_back({model_addr(wc), d});
        wc++;
        for (int i = 0; i < 4; i++) begin
            send_byte(d[8*i +: 8]);
            if (i < 3 && max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (err)  err_cnt++;
            if (done) done_cnt++;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_we", 64'(mem_we), 64'd0);
                end else begin
                    logic [42:0] e;
                    e = exp_q.pop_front();
                    chk("we_addr", 64'(mem_addr), 64'(e[42:32]));
                    chk("we_data", 64'(mem_data), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; rx_irdy = 1'b0; rx_data = 8'h00;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data", 64'(mem_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(posedge clk); #1;

        // Bytes in IDLE must be ignored.
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        pulse_start();
        chk("recv_busy", 64'(busy), 64'd1);
        wc = 0;
        send_word(32'h12345678, 0);
        for (int w = 1; w < 5; w++) send_word($urandom, 2);

        // Reset in the middle of word 5 discards it.
        send_byte(8'h5A); send_byte(8'hA5);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Full load; many words are back-to-back so bytes coincide with mem_we.
        pulse_start();
        wc = 0;
        send_word(32'hDDCCBBAA, 0);
        for (int w = 1; w < 1152; w++) send_word($urandom, (w % 3 == 0) ? 2 : 0);
        @(negedge clk);
        chk("last_we", 64'(mem_we), 64'd1);
        chk("last_addr", 64'(mem_addr), 64'h7BB);
        chk("last_done_early", 64'(done), 64'd0);
        chk("last_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("done_end", 64'(done), 64'd0);
        @(posedge clk); #1;

        // Extra bytes after completion produce no writes.
        for (int i = 0; i < 8; i++) send_byte(8'(i));
        idle_cycles(4);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_queue", 64'(exp_q.size()), 64'd0);

        // Gap between bytes.
        pulse_start();
        wc = 0;
        send_byte(8'hE0); send_byte(8'hE1);
        idle_cycles(60);
`ifdef UART_LOADER_TIMEOUT_EN
        exp_q.push_back({11'h000, 32'h04030201});
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        idle_cycles(3);
        chk("timeout_err_cnt", 64'(err_cnt), 64'd1);
`else
        exp_q.push_back({11'h000, 32'h0302E1E0});
        send_byte(8'h02); send_byte(8'h03);
        idle_cycles(3);
        chk("no_timeout_err_cnt", 64'(err_cnt), 64'd0);
`endif
        chk("gap_busy", 64'(busy), 64'd1);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
